// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU load/store path vs. debug/loader port.
// Issue/response sequencing, address checking and saturating access counters.
module dmem_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int CNT_W        = 16,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  cpu_cnt,
    output logic [CNT_W-1:0]  dbg_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t             r_state, w_state_n;
    logic               r_last_cpu, w_last_cpu_n;
    logic               r_cpu_gnt, w_cpu_gnt_n;
    logic               r_dbg_gnt, w_dbg_gnt_n;
    logic               r_cpu_rv, w_cpu_rv_n;
    logic               r_dbg_rv, w_dbg_rv_n;
    logic               r_err, w_err_n;
    logic               r_mem_en, w_mem_en_n;
    logic               r_mem_we, w_mem_we_n;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_n;
    logic [31:0]        r_mem_wdata, w_mem_wdata_n;
    logic [CNT_W-1:0]   r_cpu_cnt, w_cpu_cnt_n;
    logic [CNT_W-1:0]   r_dbg_cnt, w_dbg_cnt_n;

    logic               w_pick_cpu;
    logic               w_we;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic               w_bad;

    // r_last_cpu doubles as the port owning the in-flight access
    assign w_pick_cpu = cpu_req &&
        (!dbg_req || (CPU_PRIORITY != 0) || !r_last_cpu);
    assign w_we    = w_pick_cpu ? cpu_we    : dbg_we;
    assign w_addr  = w_pick_cpu ? cpu_addr  : dbg_addr;
    assign w_wdata = w_pick_cpu ? cpu_wdata : dbg_wdata;
    assign w_bad   = (w_addr[1:0] != 2'b00) ||
                     (w_addr[31:ADDR_W+2] != '0);

    always_comb begin
        w_state_n     = r_state;
        w_last_cpu_n  = r_last_cpu;
        w_err_n       = r_err;
        w_cpu_gnt_n   = 1'b0;
        w_dbg_gnt_n   = 1'b0;
        w_cpu_rv_n    = 1'b0;
        w_dbg_rv_n    = 1'b0;
        w_mem_en_n    = 1'b0;
        w_mem_we_n    = 1'b0;
        w_mem_addr_n  = '0;
        w_mem_wdata_n = '0;
        w_cpu_cnt_n   = r_cpu_cnt;
        w_dbg_cnt_n   = r_dbg_cnt;
        unique case (r_state)
            S_ISSUE: begin
                w_state_n  = S_RESP;
                w_cpu_rv_n = r_last_cpu;
                w_dbg_rv_n = !r_last_cpu;
            end
            default: begin
                if (cpu_req || dbg_req) begin
                    w_state_n    = S_ISSUE;
                    w_last_cpu_n = w_pick_cpu;
                    w_cpu_gnt_n  = w_pick_cpu;
                    w_dbg_gnt_n  = !w_pick_cpu;
                    w_err_n      = w_bad;
                    if (!w_bad) begin
                        w_mem_en_n    = 1'b1;
                        w_mem_we_n    = w_we;
                        w_mem_addr_n  = w_addr[ADDR_W+1:2];
                        w_mem_wdata_n = w_wdata;
                        if (w_pick_cpu && (r_cpu_cnt != '1))
                            w_cpu_cnt_n = r_cpu_cnt + 1'b1;
                        if (!w_pick_cpu && (r_dbg_cnt != '1))
                            w_dbg_cnt_n = r_dbg_cnt + 1'b1;
                    end
                end else begin
                    w_state_n = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_last_cpu  <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_gnt   <= 1'b0;
            r_dbg_gnt   <= 1'b0;
            r_cpu_rv    <= 1'b0;
            r_dbg_rv    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_cnt   <= '0;
            r_dbg_cnt   <= '0;
        end else begin
            r_state     <= w_state_n;
            r_last_cpu  <= w_last_cpu_n;
            r_err       <= w_err_n;
            r_cpu_gnt   <= w_cpu_gnt_n;
            r_dbg_gnt   <= w_dbg_gnt_n;
            r_cpu_rv    <= w_cpu_rv_n;
            r_dbg_rv    <= w_dbg_rv_n;
            r_mem_en    <= w_mem_en_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_cpu_cnt   <= w_cpu_cnt_n;
            r_dbg_cnt   <= w_dbg_cnt_n;
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign dbg_gnt    = r_dbg_gnt;
    assign cpu_rvalid = r_cpu_rv;
    assign dbg_rvalid = r_dbg_rv;
    assign cpu_err    = r_cpu_rv && r_err;
    assign dbg_err    = r_dbg_rv && r_err;
    assign cpu_rdata  = (r_cpu_rv && !r_err) ? mem_rdata : '0;
    assign dbg_rdata  = (r_dbg_rv && !r_err) ? mem_rdata : '0;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_cnt    = r_cpu_cnt;
    assign dbg_cnt    = r_dbg_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin/4-bit-counter instance plus a
// CPU-priority/16-bit-counter instance sharing stimulus, each with its own memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_mem;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

    logic        cgnt0, crv0, cerr0, dgnt0, drv0, derr0, men0, mwe0;
    logic [31:0] crd0, drd0, mwd0, mrd0;
    logic [6:0]  ma0;
    logic [3:0]  ccnt0, dcnt0;

    logic        cgnt1, crv1, cerr1, dgnt1, drv1, derr1, men1, mwe1;
    logic [31:0] crd1, drd1, mwd1, mrd1;
    logic [6:0]  ma1;
    logic [15:0] ccnt1, dcnt1;

    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] mm [128];
    bit          m_last_cpu;
    int          m_ccnt, m_dcnt;

    typedef struct {
        bit          gnt;
        int          lat;
        logic        men, mwe, rv, orv, err;
        logic [6:0]  ma;
        logic [31:0] mwd, rd;
    } obs_t;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(7), .CNT_W(4), .CPU_PRIORITY(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .cpu_gnt(cgnt0), .cpu_rvalid(crv0), .cpu_rdata(crd0), .cpu_err(cerr0),
        .dbg_gnt(dgnt0), .dbg_rvalid(drv0), .dbg_rdata(drd0), .dbg_err(derr0),
        .mem_en(men0), .mem_we(mwe0), .mem_addr(ma0), .mem_wdata(mwd0),
        .mem_rdata(mrd0), .cpu_cnt(ccnt0), .dbg_cnt(dcnt0)
    );

    dmem_arbiter #(.ADDR_W(7), .CNT_W(16), .CPU_PRIORITY(1)) dut1 (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .cpu_gnt(cgnt1), .cpu_rvalid(crv1), .cpu_rdata(crd1), .cpu_err(cerr1),
        .dbg_gnt(dgnt1), .dbg_rvalid(drv1), .dbg_rdata(drd1), .dbg_err(derr1),
        .mem_en(men1), .mem_we(mwe1), .mem_addr(ma1), .mem_wdata(mwd1),
        .mem_rdata(mrd1), .cpu_cnt(ccnt1), .dbg_cnt(dcnt1)
    );

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) mem0[i] <= '0;
        end else if (men0) begin
            if (mwe0) mem0[ma0] <= mwd0;
            mrd0 <= mem0[ma0];
        end
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) mem1[i] <= '0;
        end else if (men1) begin
            if (mwe1) mem1[ma1] <= mwd1;
            mrd1 <= mem1[ma1];
        end
    end

    function automatic bit exp_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd512);
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic do_reset();
        cpu_req = 0; dbg_req = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_ccnt = 0; m_dcnt = 0; m_last_cpu = 0;
        @(negedge clk);
    endtask

    task automatic run_single(input bit dbg, input bit we,
                              input logic [31:0] a, input logic [31:0] wd,
                              output obs_t o);
        o = '{default: '0};
        if (dbg) begin
            dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (dbg ? dgnt0 : cgnt0) begin
                o.gnt = 1; o.lat = i;
                o.men = men0; o.mwe = mwe0; o.ma = ma0; o.mwd = mwd0;
                cpu_req = 0; dbg_req = 0;
                @(negedge clk);
                o.rv  = dbg ? drv0 : crv0;
                o.orv = dbg ? crv0 : drv0;
                o.err = dbg ? derr0 : cerr0;
                o.rd  = dbg ? drd0 : crd0;
                break;
            end
        end
        cpu_req = 0; dbg_req = 0;
    endtask

    task automatic test_reset();
        init_mem = 1; rst_n = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cgnt0, dgnt0, crv0, drv0, cerr0, derr0, men0, mwe0} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 00000000",
                     {cgnt0, dgnt0, crv0, drv0, cerr0, derr0, men0, mwe0});
        end
        vectors++;
        if ({ma0, mwd0, crd0, drd0, ccnt0, dcnt0} !== '0) begin
            miscompares++;
            $display("FAIL reset_data addr %0d wd %h crd %h drd %h ccnt %0d dcnt %0d exp all 0",
                     ma0, mwd0, crd0, drd0, ccnt0, dcnt0);
        end
        init_mem = 0;
        for (int i = 0; i < 128; i++) mm[i] = '0;
        rst_n = 1;
        m_ccnt = 0; m_dcnt = 0; m_last_cpu = 0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        obs_t o;
        run_single(0, 1, 32'h60, 32'd7, o);
        vectors++;
        if (!o.gnt || o.lat != 1 || {o.men, o.mwe, o.rv, o.err, o.orv} !== 5'b11100) begin
            miscompares++;
            $display("FAIL wr_hs gnt %0d lat %0d en/we/rv/err/orv %b exp 1 1 11100",
                     o.gnt, o.lat, {o.men, o.mwe, o.rv, o.err, o.orv});
        end
        vectors++;
        if (o.ma !== 7'd24 || o.mwd !== 32'd7) begin
            miscompares++;
            $display("FAIL wr_cmd addr %0d data %0d exp 24 7", o.ma, o.mwd);
        end
        mm[24] = 32'd7; m_ccnt++;
        run_single(0, 0, 32'h60, 32'd0, o);
        vectors++;
        if (!o.gnt || {o.rv, o.err} !== 2'b10 || o.rd !== 32'd7) begin
            miscompares++;
            $display("FAIL rd_data gnt %0d rv/err %b rdata %0d exp 1 10 7",
                     o.gnt, {o.rv, o.err}, o.rd);
        end
        m_ccnt++;
        vectors++;
        if (ccnt0 !== 4'(m_ccnt) || ccnt1 !== 16'(m_ccnt)) begin
            miscompares++;
            $display("FAIL cpu_cnt got %0d/%0d exp %0d", ccnt0, ccnt1, m_ccnt);
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad [3];
        obs_t o;
        bad[0] = 32'h200; bad[1] = 32'h61; bad[2] = 32'h8000_0060;
        for (int k = 0; k < 3; k++) begin
            run_single(1, k[0], bad[k], 32'hdead_beef, o);
            vectors++;
            if (!o.gnt || o.lat != 1 || {o.men, o.mwe, o.rv, o.err, o.orv} !== 5'b00110 ||
                o.rd !== '0 || o.ma !== '0 || o.mwd !== '0) begin
                miscompares++;
                $display("FAIL err_%0d gnt %0d en/we/rv/err/orv %b rdata %h exp 1 00110 0",
                         k, o.gnt, {o.men, o.mwe, o.rv, o.err, o.orv}, o.rd);
            end
            vectors++;
            if (dcnt0 !== 4'(m_dcnt)) begin
                miscompares++;
                $display("FAIL err_cnt_%0d got %0d exp %0d", k, dcnt0, m_dcnt);
            end
        end
    endtask

    task automatic test_contention();
        int nc0, nd0, nc1, nd1;
        bit exp_cpu;
        do_reset();
        nc0 = 0; nd0 = 0; nc1 = 0; nd1 = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h4;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (cgnt0 || dgnt0) begin
                exp_cpu = !m_last_cpu;
                vectors++;
                if (cgnt0 !== exp_cpu || dgnt0 !== !exp_cpu) begin
                    miscompares++;
                    $display("FAIL rr_order grant %0d cpu/dbg %b%b exp %b%b",
                             nc0 + nd0, cgnt0, dgnt0, exp_cpu, !exp_cpu);
                end
                m_last_cpu = exp_cpu;
                if (cgnt0) nc0++; else nd0++;
            end
            if (cgnt1) nc1++;
            if (dgnt1) nd1++;
        end
        cpu_req = 0; dbg_req = 0;
        vectors++;
        if (nc0 != 4 || nd0 != 4 || nc1 != 8 || nd1 != 0) begin
            miscompares++;
            $display("FAIL contention_counts rr %0d/%0d prio %0d/%0d exp 4/4 8/0",
                     nc0, nd0, nc1, nd1);
        end
        m_ccnt += 4; m_dcnt += 4;
        vectors++;
        if (ccnt0 !== 4'(m_ccnt) || dcnt0 !== 4'(m_dcnt)) begin
            miscompares++;
            $display("FAIL contention_cnt got %0d/%0d exp %0d/%0d",
                     ccnt0, dcnt0, m_ccnt, m_dcnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        obs_t o;
        bit dbg, we, e;
        logic [31:0] a, wd, exp_rd;
        int r;
        for (int n = 0; n < 40; n++) begin
            dbg = 1'($urandom % 2);
            we  = 1'($urandom % 2);
            wd  = $urandom;
            r   = int'($urandom % 8);
            if (r == 0)      a = $urandom | 32'h200;
            else if (r == 1) a = ($urandom % 128) * 4 + 1 + ($urandom % 3);
            else             a = ($urandom % 16) * 4;
            e = exp_bad(a);
            exp_rd = (!we && !e) ? mm[a / 4] : '0;
            run_single(dbg, we, a, wd, o);
            vectors++;
            if (!o.gnt || o.lat != 1 || o.rv !== 1'b1 || o.orv !== 1'b0 ||
                o.err !== e || o.men !== !e ||
                (!e && (o.ma !== 7'(a / 4) || o.mwe !== we)) ||
                (!we && o.rd !== exp_rd)) begin
                miscompares++;
                $display("FAIL rand_%0d port %0d we %0d addr %h gnt %0d rv %b err %b en %b rdata %h exp err %b rdata %h",
                         n, dbg, we, a, o.gnt, o.rv, o.err, o.men, o.rd, e, exp_rd);
            end
            if (!e) begin
                if (we) mm[a / 4] = wd;
                if (dbg) m_dcnt++; else m_ccnt++;
            end
            vectors++;
            if (ccnt0 !== 4'(sat15(m_ccnt)) || dcnt0 !== 4'(sat15(m_dcnt))) begin
                miscompares++;
                $display("FAIL rand_cnt_%0d got %0d/%0d exp %0d/%0d",
                         n, ccnt0, dcnt0, sat15(m_ccnt), sat15(m_dcnt));
            end
            repeat ($urandom % 3) @(negedge clk);
        end
    endtask

    task automatic test_reset_issue();
        bit seen;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h5;
        @(negedge clk);
        vectors++;
        if (cgnt0 !== 1'b1 || men0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_issue_pre gnt %b en %b exp 1 1", cgnt0, men0);
        end
        rst_n = 0;
        #1;
        vectors++;
        if (cgnt0 !== 1'b0 || men0 !== 1'b0 || ccnt0 !== 4'd0 || dcnt0 !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_issue_clear gnt %b en %b ccnt %0d dcnt %0d exp 0 0 0 0",
                     cgnt0, men0, ccnt0, dcnt0);
        end
        cpu_req = 0;
        @(negedge clk);
        rst_n = 1;
        m_ccnt = 0; m_dcnt = 0; m_last_cpu = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (crv0 || men0) seen = 1;
        end
        vectors++;
        if (seen || ccnt0 !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_issue_after activity %0d ccnt %0d exp 0 0", seen, ccnt0);
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        for (int k = 1; k <= 20; k++) begin
            run_single(1, 1, 32'(k * 4), 32'(k), o);
            mm[k] = 32'(k);
            m_dcnt++;
            vectors++;
            if (!o.gnt || dcnt0 !== 4'(sat15(m_dcnt))) begin
                miscompares++;
                $display("FAIL sat_%0d gnt %0d dbg_cnt %0d exp %0d",
                         k, o.gnt, dcnt0, sat15(m_dcnt));
            end
        end
        vectors++;
        if (dcnt1 !== 16'(m_dcnt)) begin
            miscompares++;
            $display("FAIL sat_wide dbg_cnt %0d exp %0d", dcnt1, m_dcnt);
        end
    endtask

    initial begin
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        test_reset();
        test_write_read();
        test_errors();
        test_contention();
        test_random();
        test_reset_issue();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
